// File: rtl/apb_master_bridge21.sv
// APB initiator bridge: accepts one command at a time on a valid/ready request
// channel, runs the APB SETUP/ACCESS handshake on one of NUM_SLAVES21 select
// lines, and returns read data plus error status on a valid/ready response
// channel. A wait-state timeout aborts transfers whose slave never raises pready21.
module apb_master_bridge21 #(
  parameter int PADDR_WIDTH21  = 32,
  parameter int PWDATA_WIDTH21 = 32,
  parameter int PRDATA_WIDTH21 = 32,
  parameter int NUM_SLAVES21   = 4,
  parameter int TIMEOUT21      = 16
) (
  input  logic                      pclock21,
  input  logic                      preset21,
  // request channel
  input  logic                      req_valid21,
  output logic                      req_ready21,
  input  logic                      req_write21,
  input  logic [3:0]                req_sel21,
  input  logic [PADDR_WIDTH21-1:0]  req_addr21,
  input  logic [PWDATA_WIDTH21-1:0] req_wdata21,
  // response channel
  output logic                      rsp_valid21,
  input  logic                      rsp_ready21,
  output logic [PRDATA_WIDTH21-1:0] rsp_rdata21,
  output logic                      rsp_slverr21,
  output logic                      rsp_timeout21,
  // APB initiator side
  output logic [PADDR_WIDTH21-1:0]  paddr21,
  output logic                      prwd21,
  output logic [PWDATA_WIDTH21-1:0] pwdata21,
  output logic [NUM_SLAVES21-1:0]   psel21,
  output logic                      penable21,
  input  logic [PRDATA_WIDTH21-1:0] prdata21,
  input  logic                      pready21,
  input  logic                      pslverr21
);

  // Counter wide enough to hold TIMEOUT21 itself.
  localparam int CNT_W = (TIMEOUT21 > 1) ? $clog2(TIMEOUT21 + 1) : 1;
  // Count value seen on the last permitted stalled ACCESS cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT21 > 0) ? CNT_W'(TIMEOUT21 - 1) : '0;
  // Select indices at or above this value have no psel21 line.
  localparam logic [4:0] NUM_SEL = 5'(NUM_SLAVES21);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [PADDR_WIDTH21-1:0]  addr_q, addr_d;
  logic [PWDATA_WIDTH21-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic [3:0]                sel_q, sel_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PRDATA_WIDTH21-1:0] rdata_q, rdata_d;
  logic                      slverr_q, slverr_d;
  logic                      timeout_q, timeout_d;

  logic                      sel_ok;
  logic                      bus_active;

  assign sel_ok = ({1'b0, req_sel21} < NUM_SEL);

  // Next-state and next-register computation for the whole transfer sequence.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    timeout_d = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid21) begin
          addr_d  = req_addr21;
          wdata_d = req_wdata21;
          write_d = req_write21;
          sel_d   = req_sel21;
          if (sel_ok) begin
            state_d = S_SETUP;
          end else begin
            // No slave behind this index: answer with an error, never touch the bus.
            state_d   = S_RESP;
            rdata_d   = '0;
            slverr_d  = 1'b1;
            timeout_d = 1'b0;
          end
        end
      end

      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end

      S_ACCESS: begin
        if (pready21) begin
          // Read data is only meaningful for a read the slave completed cleanly.
          rdata_d   = (write_q || pslverr21) ? '0 : prdata21;
          slverr_d  = pslverr21;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else if ((TIMEOUT21 != 0) && (cnt_q == CNT_LAST)) begin
          cnt_d     = cnt_q + CNT_W'(1);
          rdata_d   = '0;
          slverr_d  = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready21) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state register; reset abandons any transfer in flight.
  always_ff @(posedge pclock21 or posedge preset21) begin
    if (preset21) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transfer attributes, wait-state counter and response holding registers.
  always_ff @(posedge pclock21 or posedge preset21) begin
    if (preset21) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      sel_q     <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus_active = (state_q == S_SETUP) || (state_q == S_ACCESS);

  // One-hot select decoded from the registered index while the bus is owned.
  always_comb begin
    psel21 = '0;
    for (int i = 0; i < NUM_SLAVES21; i++) begin
      psel21[i] = bus_active && (sel_q == 4'(i));
    end
  end

  assign req_ready21   = (state_q == S_IDLE);
  assign rsp_valid21   = (state_q == S_RESP);
  assign penable21     = (state_q == S_ACCESS);
  assign paddr21       = addr_q;
  assign pwdata21      = wdata_q;
  assign prwd21        = write_q;
  assign rsp_rdata21   = rdata_q;
  assign rsp_slverr21  = slverr_q;
  assign rsp_timeout21 = timeout_q;

  // Bus sanity: select never multi-hot, enable only with a select asserted.
  a_psel_onehot0: assert property (@(posedge pclock21) disable iff (preset21)
    $onehot0(psel21));
  a_penable_sel: assert property (@(posedge pclock21) disable iff (preset21)
    penable21 |-> (psel21 != '0));

endmodule
